plus_one: RTL and testbench

- Registered single-stage incrementer with a carry/overflow flag and a valid/ready handshake on both sides.
- Counterpart of the team's decrement-with-underflow block: it adds 1 where that block subtracts 1.
- Sits in the nap-timer datapath and steps count values upward.
- Keeps a saturating count of overflow events for status readout.

---
 rtl/plus_one_pkg.sv | 11 +
 rtl/plus_one.sv | 87 ++++++++
 tb/tb_plus_one.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/plus_one_pkg.sv
// Shared constants for the plus_one incrementer: state encoding (matches the
// decrement-with-underflow block so debug decoders treat both alike) and widths.
package plus_one_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic [1:0] ST_INIT   = 2'd2;
  localparam logic [1:0] ST_NORMAL = 2'd1;
  localparam logic [1:0] ST_OVER   = 2'd0;

endpackage

// File: rtl/plus_one.sv
// Registered single-stage incrementer with overflow flag, valid/ready on both
// sides and a saturating count of overflow operands.
module plus_one
  import plus_one_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter bit WRAP  = 1'b1,
  parameter int OVF_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic [WIDTH-1:0] Res,
  output logic             Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OVF_W-1:0] ovf_count,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, ready may depend on out_ready.

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [OVF_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             legal;
  logic             full;
  logic             accept;
  logic             consume;

  assign sum   = {1'b0, in} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf   = sum[WIDTH];
  assign full  = (state_q == ST_NORMAL) || (state_q == ST_OVER);
  assign legal = full || (state_q == ST_INIT);

  assign in_ready = !clear && ((state_q == ST_INIT) || (full && out_ready));
  assign accept   = in_valid && in_ready;
  assign consume  = full && out_ready && !clear;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else if (!legal) begin
      state_d = ST_INIT;
      res_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      // Accept during consume simply overwrites: no empty bubble.
      state_d = ovf ? ST_OVER : ST_NORMAL;
      res_d   = (ovf && !WRAP) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      if (ovf && (cnt_q != {OVF_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (consume) begin
      state_d = ST_INIT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = full;
  assign Cout        = (state_q == ST_OVER);
  assign Res         = legal ? res_q : '0;
  assign ovf_count   = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_plus_one.sv
// Randomised and directed bench for plus_one: three instances (wrap, saturate,
// narrow counter) share stimulus and are checked against a one-slot model.
module tb_plus_one;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [3:0] din;
  logic       out_ready;

  logic       in_ready_w [3];
  logic [3:0] res_w      [3];
  logic       cout_w     [3];
  logic       valid_w    [3];
  logic [1:0] state_w    [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int         cnt_w      [3];

  int checks = 0;
  int errors = 0;

  // model state per instance
  bit         m_full [3];
  bit         m_cout [3];
  logic [3:0] m_res  [3];
  int         m_cnt  [3];
  bit         wrap_p [3] = '{1'b1, 1'b0, 1'b1};
  int         cmax_p [3] = '{255, 255, 3};

  plus_one #(.WIDTH(4), .WRAP(1'b1), .OVF_W(8)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in(din),
    .in_ready(in_ready_w[0]), .Res(res_w[0]), .Cout(cout_w[0]), .out_valid(valid_w[0]),
    .out_ready(out_ready), .ovf_count(cnt0), .dbg_state_o(state_w[0]));

  plus_one #(.WIDTH(4), .WRAP(1'b0), .OVF_W(8)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in(din),
    .in_ready(in_ready_w[1]), .Res(res_w[1]), .Cout(cout_w[1]), .out_valid(valid_w[1]),
    .out_ready(out_ready), .ovf_count(cnt1), .dbg_state_o(state_w[1]));

  plus_one #(.WIDTH(4), .WRAP(1'b1), .OVF_W(2)) dut2 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in(din),
    .in_ready(in_ready_w[2]), .Res(res_w[2]), .Cout(cout_w[2]), .out_valid(valid_w[2]),
    .out_ready(out_ready), .ovf_count(cnt2), .dbg_state_o(state_w[2]));

  assign cnt_w[0] = int'(cnt0);
  assign cnt_w[1] = int'(cnt1);
  assign cnt_w[2] = int'(cnt2);

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: at most one result held
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        m_full[d] <= 1'b0;
        m_cout[d] <= 1'b0;
        m_res[d]  <= 4'h0;
        m_cnt[d]  <= 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (clear) begin
          m_full[d] <= 1'b0;
          m_cout[d] <= 1'b0;
          m_cnt[d]  <= 0;
        end else if (in_valid && (!m_full[d] || out_ready)) begin
          m_full[d] <= 1'b1;
          m_cout[d] <= (din == 4'hF);
          if (din == 4'hF) m_res[d] <= wrap_p[d] ? 4'h0 : 4'hF;
          else             m_res[d] <= din + 4'h1;
          if (din == 4'hF && m_cnt[d] < cmax_p[d]) m_cnt[d] <= m_cnt[d] + 1;
        end else if (m_full[d] && out_ready) begin
          m_full[d] <= 1'b0;
        end
      end
    end
  end

  // compare process
  always @(negedge clock) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("out_valid[%0d]", d), int'(valid_w[d]), int'(m_full[d]));
        chk($sformatf("Cout[%0d]", d), int'(cout_w[d]), int'(m_full[d] && m_cout[d]));
        chk($sformatf("Res[%0d]", d), int'(res_w[d]), int'(m_res[d]));
        chk($sformatf("ovf_count[%0d]", d), cnt_w[d], m_cnt[d]);
        chk($sformatf("in_ready[%0d]", d), int'(in_ready_w[d]),
            int'(!clear && (!m_full[d] || out_ready)));
        chk($sformatf("state[%0d]", d), int'(state_w[d]),
            !m_full[d] ? 2 : (m_cout[d] ? 0 : 1));
      end
    end
  end

  // driver
  task automatic cyc(input bit v, input logic [3:0] d, input bit ordy, input bit clr);
    @(posedge clock);
    #1;
    in_valid  = v;
    din       = d;
    out_ready = ordy;
    clear     = clr;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; din = 4'h0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_Res", int'(res_w[0]), 0);
    chk("rst_valid", int'(valid_w[0]), 0);
    chk("rst_Cout", int'(cout_w[0]), 0);
    chk("rst_cnt", cnt_w[0], 0);
    chk("rst_in_ready", int'(in_ready_w[0]), 1);

    // 5 -> 6
    cyc(1, 4'h5, 1, 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("lit_res6", int'(res_w[0]), 6);
    chk("lit_cout6", int'(cout_w[0]), 0);
    chk("lit_valid6", int'(valid_w[0]), 1);

    // F wraps / saturates
    cyc(1, 4'hF, 1, 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("lit_wrap_res", int'(res_w[0]), 0);
    chk("lit_wrap_cout", int'(cout_w[0]), 1);
    chk("lit_wrap_cnt", cnt_w[0], 1);
    chk("lit_sat_res", int'(res_w[1]), 15);
    chk("lit_sat_cout", int'(cout_w[1]), 1);

    // backpressure
    cyc(1, 4'h3, 1, 0);
    repeat (5) begin
      cyc(1, 4'h7, 0, 0);
      @(negedge clock);
      chk("bp_res", int'(res_w[0]), 4);
      chk("bp_in_ready", int'(in_ready_w[0]), 0);
    end
    cyc(1, 4'h7, 1, 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("bp_res8", int'(res_w[0]), 8);
    chk("bp_valid8", int'(valid_w[0]), 1);

    // back-to-back stream 0..15
    cyc(0, 4'h0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, 4'(i), 1, 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("stream_last_res", int'(res_w[0]), 0);
    chk("stream_last_cout", int'(cout_w[0]), 1);
    chk("stream_cnt", cnt_w[0], 1);

    // narrow counter saturation, then clear
    cyc(0, 4'h0, 1, 1);
    repeat (5) cyc(1, 4'hF, 1, 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("sat_cnt2", cnt_w[2], 3);
    chk("sat_cnt0", cnt_w[0], 5);
    cyc(1, 4'hF, 1, 1);
    @(negedge clock);
    chk("clr_in_ready", int'(in_ready_w[2]), 0);
    cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    chk("clr_cnt2", cnt_w[2], 0);
    chk("clr_valid", int'(valid_w[2]), 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 40) == 0));
    end

    // asynchronous reset while holding a result
    cyc(1, 4'h2, 0, 0);
    cyc(0, 4'h0, 0, 0);
    @(negedge clock);
    chk("pre_arst_valid", int'(valid_w[0]), 1);
    chk("pre_arst_res", int'(res_w[0]), 3);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", int'(valid_w[0]), 0);
    chk("arst_res", int'(res_w[0]), 0);
    chk("arst_cout", int'(cout_w[0]), 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", int'(in_ready_w[0]), 1);

    repeat (3) cyc(0, 4'h0, 1, 0);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
